// File: rtl/connect_suite_pt_pkg.sv
// Shared types and constants for the pass-through round-robin arbiter.
package connect_suite_pt_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned IDX_W   = 2;

    typedef logic [IDX_W-1:0] req_idx_t;
    typedef logic [WIDTH-1:0] data_t;

    // Contents of the single output register
    typedef struct packed {
        req_idx_t chosen;
        data_t    bits;
    } out_beat_t;

    function automatic logic [NUM_REQ-1:0] idx_onehot(input req_idx_t idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/connect_suite_pt_arbiter_if.sv
// Requester and downstream channels of the arbiter; io_lock exists only with PT_ARB_LOCK_EN.
interface connect_suite_pt_arbiter_if;
    import connect_suite_pt_pkg::*;

    logic     io_in_0_valid, io_in_1_valid, io_in_2_valid, io_in_3_valid;
    data_t    io_in_0_bits,  io_in_1_bits,  io_in_2_bits,  io_in_3_bits;
    logic     io_in_0_ready, io_in_1_ready, io_in_2_ready, io_in_3_ready;
    logic     io_out_valid;
    data_t    io_out_bits;
    req_idx_t io_out_chosen;
    logic     io_out_ready;
`ifdef PT_ARB_LOCK_EN
    logic     io_lock;

    modport slave (
        input  io_in_0_valid, io_in_1_valid, io_in_2_valid, io_in_3_valid,
        input  io_in_0_bits,  io_in_1_bits,  io_in_2_bits,  io_in_3_bits,
        output io_in_0_ready, io_in_1_ready, io_in_2_ready, io_in_3_ready,
        output io_out_valid, io_out_bits, io_out_chosen,
        input  io_out_ready, io_lock
    );

    modport master (
        output io_in_0_valid, io_in_1_valid, io_in_2_valid, io_in_3_valid,
        output io_in_0_bits,  io_in_1_bits,  io_in_2_bits,  io_in_3_bits,
        input  io_in_0_ready, io_in_1_ready, io_in_2_ready, io_in_3_ready,
        input  io_out_valid, io_out_bits, io_out_chosen,
        output io_out_ready, io_lock
    );
`else
    modport slave (
        input  io_in_0_valid, io_in_1_valid, io_in_2_valid, io_in_3_valid,
        input  io_in_0_bits,  io_in_1_bits,  io_in_2_bits,  io_in_3_bits,
        output io_in_0_ready, io_in_1_ready, io_in_2_ready, io_in_3_ready,
        output io_out_valid, io_out_bits, io_out_chosen,
        input  io_out_ready
    );

    modport master (
        output io_in_0_valid, io_in_1_valid, io_in_2_valid, io_in_3_valid,
        output io_in_0_bits,  io_in_1_bits,  io_in_2_bits,  io_in_3_bits,
        input  io_in_0_ready, io_in_1_ready, io_in_2_ready, io_in_3_ready,
        input  io_out_valid, io_out_bits, io_out_chosen,
        output io_out_ready
    );
`endif

endinterface

// File: rtl/connect_suite_rr_pick.sv
// Combinational round-robin picker: first valid requester after 'last', wrapping to 'last' itself.
module connect_suite_rr_pick
    import connect_suite_pt_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  req_idx_t           last,
    output logic               grant_valid,
    output req_idx_t           grant
);

    // Scan from the farthest offset down so the nearest valid requester wins.
    always_comb begin
        req_idx_t idx;
        grant_valid = 1'b0;
        grant       = '0;
        idx         = '0;
        for (int k = int'(NUM_REQ); k > 0; k--) begin
            idx = last + IDX_W'(k);
            if (valid[idx]) begin
                grant_valid = 1'b1;
                grant       = idx;
            end
        end
    end

endmodule

// File: rtl/connect_suite_pt_arbiter.sv
// Round-robin scheduler of four requesters onto one registered pass-through stage.
// Optional burst lock (io_lock) is built when PT_ARB_LOCK_EN is defined.
module connect_suite_pt_arbiter
    import connect_suite_pt_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset_n,
    connect_suite_pt_arbiter_if.slave   bus
);

    logic                out_valid;
    out_beat_t           out_q;
    req_idx_t            last;

    logic                accept_c;
    logic [NUM_REQ-1:0]  valid_vec;
    logic [NUM_REQ-1:0]  cand_vec;
    logic [NUM_REQ-1:0]  ready_vec;
    logic                grant_valid;
    req_idx_t            grant;
    data_t               sel_bits;

    assign valid_vec = {bus.io_in_3_valid, bus.io_in_2_valid, bus.io_in_1_valid, bus.io_in_0_valid};
    assign accept_c  = !out_valid || bus.io_out_ready;

`ifdef PT_ARB_LOCK_EN
    // A locked burst only lets the current owner through, even when it is idle.
    assign cand_vec = (bus.io_lock && out_valid) ? (valid_vec & idx_onehot(out_q.chosen)) : valid_vec;
`else
    assign cand_vec = valid_vec;
`endif

    connect_suite_rr_pick u_pick (
        .valid       (cand_vec),
        .last        (last),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_comb begin
        sel_bits = bus.io_in_0_bits;
        case (grant)
            2'd1:    sel_bits = bus.io_in_1_bits;
            2'd2:    sel_bits = bus.io_in_2_bits;
            2'd3:    sel_bits = bus.io_in_3_bits;
            default: sel_bits = bus.io_in_0_bits;
        endcase
    end

    assign ready_vec = (accept_c && grant_valid) ? idx_onehot(grant) : '0;

    assign bus.io_in_0_ready = ready_vec[0];
    assign bus.io_in_1_ready = ready_vec[1];
    assign bus.io_in_2_ready = ready_vec[2];
    assign bus.io_in_3_ready = ready_vec[3];

    // Output register drains and refills in the same cycle when downstream is ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            last      <= IDX_W'(NUM_REQ - 1);
        end else if (accept_c) begin
            if (grant_valid) begin
                out_valid    <= 1'b1;
                out_q.bits   <= sel_bits;
                out_q.chosen <= grant;
                last         <= grant;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.io_out_valid  = out_valid;
    assign bus.io_out_bits   = out_q.bits;
    assign bus.io_out_chosen = out_q.chosen;

endmodule

// File: tb/tb_connect_suite_pt_arbiter.sv
// Directed and randomized bench for connect_suite_pt_arbiter against a round-robin reference model.
module tb_connect_suite_pt_arbiter;
    import connect_suite_pt_pkg::*;

    logic  clk;
    logic  reset_n;
    logic  in_valid [4];
    data_t in_bits  [4];
    logic  out_ready;
    logic  in_lock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic  m_valid;
    data_t m_bits;
    int    m_chosen;
    int    m_last;
    int    last_g;
    logic [3:0] m_accepted;

    connect_suite_pt_arbiter_if bus();

    assign bus.io_in_0_valid = in_valid[0];
    assign bus.io_in_1_valid = in_valid[1];
    assign bus.io_in_2_valid = in_valid[2];
    assign bus.io_in_3_valid = in_valid[3];
    assign bus.io_in_0_bits  = in_bits[0];
    assign bus.io_in_1_bits  = in_bits[1];
    assign bus.io_in_2_bits  = in_bits[2];
    assign bus.io_in_3_bits  = in_bits[3];
    assign bus.io_out_ready  = out_ready;
`ifdef PT_ARB_LOCK_EN
    assign bus.io_lock       = in_lock;
`endif

    connect_suite_pt_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] readies();
        return {bus.io_in_3_ready, bus.io_in_2_ready, bus.io_in_1_ready, bus.io_in_0_ready};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Grant rule: nearest valid requester after the last grant, wrapping around to it.
    function automatic int exp_grant();
`ifdef PT_ARB_LOCK_EN
        if (in_lock && m_valid)
            return in_valid[m_chosen] ? m_chosen : -1;
`endif
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (m_last + k) % 4;
            if (in_valid[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock: check readies and outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        int g;
        logic acc;
        logic [3:0] exp_rdy;
        @(negedge clk);
        g   = exp_grant();
        acc = !m_valid || out_ready;
        exp_rdy = (acc && g >= 0) ? 4'(1 << g) : 4'b0000;
        check("ready", 32'(readies()), 32'(exp_rdy));
        check("out_valid", 32'(bus.io_out_valid), 32'(m_valid));
        if (m_valid) begin
            check("out_bits", 32'(bus.io_out_bits), 32'(m_bits));
            check("out_chosen", 32'(bus.io_out_chosen), 32'(m_chosen));
        end
        @(posedge clk);
        m_accepted = exp_rdy;
        last_g = (acc && g >= 0) ? g : -1;
        if (acc) begin
            if (g >= 0) begin
                m_valid  = 1'b1;
                m_bits   = in_bits[g];
                m_chosen = g;
                m_last   = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear with no clock edge.
    task automatic do_reset();
        for (int n = 0; n < 4; n++) begin
            in_valid[n] = 1'b0;
            in_bits[n]  = '0;
        end
        out_ready = 1'b0;
        in_lock   = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.io_out_valid), 32'd0);
        check("rst_out_bits", 32'(bus.io_out_bits), 32'd0);
        check("rst_out_chosen", 32'(bus.io_out_chosen), 32'd0);
        m_valid    = 1'b0;
        m_bits     = '0;
        m_chosen   = 0;
        m_last     = 3;
        last_g     = -1;
        m_accepted = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        for (int n = 0; n < 4; n++) begin
            in_valid[n] = 1'b0;
            in_bits[n]  = '0;
        end
        out_ready = 1'b0;
        in_lock   = 1'b0;

        // Reset then single requester 2
        do_reset();
        in_valid[2] = 1'b1;
        in_bits[2]  = 8'hA5;
        out_ready   = 1'b1;
        cycle();
        check("single_grant", 32'(last_g), 32'd2);
        in_valid[2] = 1'b0;
        check("single_out_valid", 32'(bus.io_out_valid), 32'd1);
        check("single_out_bits", 32'(bus.io_out_bits), 32'hA5);
        check("single_out_chosen", 32'(bus.io_out_chosen), 32'd2);
        cycle();

        // Round-robin fairness with all requesters valid
        do_reset();
        for (int n = 0; n < 4; n++) begin
            in_valid[n] = 1'b1;
            in_bits[n]  = 8'(8'h10 + n);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("rr_grant", 32'(last_g), 32'(i % 4));
            check("rr_out_valid", 32'(bus.io_out_valid), 32'd1);
            check("rr_out_chosen", 32'(bus.io_out_chosen), 32'(i % 4));
            check("rr_out_bits", 32'(bus.io_out_bits), 32'(8'h10 + i % 4));
        end

        // Backpressure holds the register and blocks every requester
        begin
            data_t held;
            held = bus.io_out_bits;
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                cycle();
                check("bp_grant_none", 32'(last_g), 32'hFFFF_FFFF);
                check("bp_bits_stable", 32'(bus.io_out_bits), 32'(held));
            end
        end
        out_ready = 1'b1;
        cycle();
        check("bp_refill_grant", 32'(last_g), 32'd0);
        check("bp_refill_valid", 32'(bus.io_out_valid), 32'd1);
        check("bp_refill_chosen", 32'(bus.io_out_chosen), 32'd0);

        // Skip idle requesters: last = 0, only 0 and 3 valid
        in_valid[1] = 1'b0;
        in_valid[2] = 1'b0;
        in_bits[0]  = 8'h20;
        in_bits[3]  = 8'h23;
        cycle();
        check("skip_first", 32'(last_g), 32'd3);
        cycle();
        check("skip_second", 32'(last_g), 32'd0);
        check("skip_bits", 32'(bus.io_out_bits), 32'h20);

        // Async reset while output is valid, then lowest-index priority
        check("pre_reset_valid", 32'(bus.io_out_valid), 32'd1);
        do_reset();
        in_valid[1] = 1'b1;
        in_bits[1]  = 8'h31;
        in_valid[3] = 1'b1;
        in_bits[3]  = 8'h33;
        out_ready   = 1'b1;
        cycle();
        check("post_reset_grant", 32'(last_g), 32'd1);

`ifdef PT_ARB_LOCK_EN
        // Burst lock keeps grants on requester 1
        do_reset();
        out_ready   = 1'b1;
        in_valid[1] = 1'b1;
        in_bits[1]  = 8'h41;
        cycle();
        check("lock_setup", 32'(last_g), 32'd1);
        in_lock     = 1'b1;
        in_valid[2] = 1'b1;
        in_bits[2]  = 8'h42;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("lock_hold", 32'(last_g), 32'd1);
        end
        in_lock = 1'b0;
        cycle();
        check("lock_release", 32'(last_g), 32'd2);
`endif

        // Randomized traffic obeying the upstream hold-until-ready rule
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < 4; n++) begin
                if (!in_valid[n] || m_accepted[n]) begin
                    in_valid[n] = ($urandom_range(0, 2) != 0);
                    in_bits[n]  = 8'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef PT_ARB_LOCK_EN
            in_lock = ($urandom_range(0, 4) == 0);
`endif
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
